// File: rtl/xbar_bridge_rr_arbiter_pkg.sv
// Shared helpers for the per-slave round-robin arbiter of the L2 TCDM bridge.
package xbar_bridge_rr_arbiter_pkg;

    // Next index in a ring of n entries: n-1 wraps back to 0, so the result
    // always stays below n even when n is not a power of two.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/xbar_bridge_rr_arbiter_rr_prio_encoder.sv
// Rotating priority encoder: finds the first set request at or after the
// start pointer, wrapping from N_MASTER-1 back to 0.
module rr_prio_encoder #(
    parameter  int N_MASTER = 16,
    localparam int LOG_N    = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req_i,
    input  logic [LOG_N-1:0]    start_i,
    output logic                found_o,
    output logic [LOG_N-1:0]    idx_o
);

    int               cand_s;
    logic [LOG_N-1:0] cand_idx_s;

    // Scan the ring starting at start_i and keep the first requester seen.
    always_comb begin
        found_o    = 1'b0;
        idx_o      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            cand_s = int'(start_i) + k;
            if (cand_s >= N_MASTER) begin
                cand_s = cand_s - N_MASTER;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = LOG_N'(cand_s);
            if (!found_o && req_i[cand_idx_s]) begin
                found_o = 1'b1;
                idx_o   = cand_idx_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/xbar_bridge_rr_arbiter.sv
// Per-slave round-robin arbiter of the L2 TCDM bridge crossbar. Grants one
// master per cycle, keeps the winner locked while the slave stalls and steers
// the one-cycle-latency response back to the master of the last handshake.
module xbar_bridge_rr_arbiter
    import xbar_bridge_rr_arbiter_pkg::*;
#(
    parameter int N_MASTER   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_MASTER
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    output logic [ID_WIDTH-1:0]            data_ID_o,
    input  logic                           data_gnt_i,
    input  logic                           data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]          data_r_rdata_o
);

    localparam int LOG_N = $clog2(N_MASTER);

    logic [LOG_N-1:0] rr_q;
    logic             lock_q;
    logic [LOG_N-1:0] lock_idx_q;
    logic [LOG_N-1:0] r_idx_q;

    logic             found_s;
    logic [LOG_N-1:0] enc_idx_s;
    logic [LOG_N-1:0] winner_s;
    logic             req_s;
    logic             hs_s;

    logic [ADDR_WIDTH-1:0] add_arr_s   [N_MASTER];
    logic [DATA_WIDTH-1:0] wdata_arr_s [N_MASTER];
    logic [BE_WIDTH-1:0]   be_arr_s    [N_MASTER];
    logic [ID_WIDTH-1:0]   id_arr_s    [N_MASTER];

    for (genvar m = 0; m < N_MASTER; m++) begin : g_unpack
        assign add_arr_s[m]   = data_add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr_s[m] = data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr_s[m]    = data_be_i[m*BE_WIDTH +: BE_WIDTH];
        assign id_arr_s[m]    = data_ID_i[m*ID_WIDTH +: ID_WIDTH];
    end

    rr_prio_encoder #(
        .N_MASTER (N_MASTER)
    ) u_prio_enc (
        .req_i   (data_req_i),
        .start_i (rr_q),
        .found_o (found_s),
        .idx_o   (enc_idx_s)
    );

    // Pick the winner: the locked master during a stall, else the rotating scan.
    // The request is held off while reset is asserted so every output reads 0.
    always_comb begin
        winner_s = '0;
        req_s    = 1'b0;
        if (lock_q) begin
            winner_s = lock_idx_q;
            req_s    = data_req_i[lock_idx_q] & rst_n;
        end else begin
            winner_s = enc_idx_s;
            req_s    = found_s & rst_n;
        end
    end

    assign hs_s = req_s & data_gnt_i;

    // Forward the winner's payload and grant; everything reads 0 when idle.
    always_comb begin
        data_req_o   = req_s;
        data_add_o   = '0;
        data_wen_o   = 1'b0;
        data_wdata_o = '0;
        data_be_o    = '0;
        data_ID_o    = '0;
        data_gnt_o   = '0;
        if (req_s) begin
            data_add_o   = add_arr_s[winner_s];
            data_wen_o   = data_wen_i[winner_s];
            data_wdata_o = wdata_arr_s[winner_s];
            data_be_o    = be_arr_s[winner_s];
            data_ID_o    = id_arr_s[winner_s];
            data_gnt_o[winner_s] = data_gnt_i;
        end else begin
            data_req_o = 1'b0;
        end
    end

    // Arbitration state: advance the pointer on handshake, lock on stall,
    // and release a lock whose master withdrew its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            r_idx_q    <= '0;
        end else if (hs_s) begin
            rr_q    <= LOG_N'(rr_wrap_inc(int'(winner_s), N_MASTER));
            lock_q  <= 1'b0;
            r_idx_q <= winner_s;
        end else if (req_s) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner_s;
        end else begin
            lock_q <= 1'b0;
        end
    end

    // Steer the response valid to the master of the previous handshake;
    // a response arriving while reset is asserted is dropped.
    always_comb begin
        data_r_valid_o = '0;
        if (data_r_valid_i && rst_n) begin
            data_r_valid_o[r_idx_q] = 1'b1;
        end else begin
            data_r_valid_o = '0;
        end
    end

    assign data_r_rdata_o = data_r_rdata_i;

endmodule

// File: tb/tb_xbar_bridge_rr_arbiter.sv
// Bench for xbar_bridge_rr_arbiter with four masters: directed scenarios
// followed by randomized traffic, all checked against a transaction-level model.
module tb_xbar_bridge_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    data_req_i;
    logic [N*AW-1:0] data_add_i;
    logic [N-1:0]    data_wen_i;
    logic [N*DW-1:0] data_wdata_i;
    logic [N*BW-1:0] data_be_i;
    logic [N*IW-1:0] data_ID_i;
    logic [N-1:0]    data_gnt_o;
    logic            data_req_o;
    logic [AW-1:0]   data_add_o;
    logic            data_wen_o;
    logic [DW-1:0]   data_wdata_o;
    logic [BW-1:0]   data_be_o;
    logic [IW-1:0]   data_ID_o;
    logic            data_gnt_i;
    logic            data_r_valid_i;
    logic [DW-1:0]   data_r_rdata_i;
    logic [N-1:0]    data_r_valid_o;
    logic [DW-1:0]   data_r_rdata_o;

    always #5 clk = ~clk;

    xbar_bridge_rr_arbiter #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
        .data_gnt_o(data_gnt_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
        .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i),
        .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
        .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // per-master payload the masters present
    logic [AW-1:0] p_add   [N];
    logic          p_wen   [N];
    logic [DW-1:0] p_wdata [N];
    logic [BW-1:0] p_be    [N];
    logic [IW-1:0] p_id    [N];

    // transaction-level model state
    int m_ptr     = 0;
    bit m_locked  = 0;
    int m_lock_m  = 0;
    int m_rtarget = 0;
    bit m_hs_prev = 0;
    bit last_hs   = 0;
    int last_win  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int m);
        p_add[m]   = $urandom;
        p_wen[m]   = 1'($urandom_range(0, 1));
        p_wdata[m] = $urandom;
        p_be[m]    = 4'($urandom_range(0, 15));
    endtask

    // One cycle: drive inputs mid-cycle, predict outputs, compare, advance model.
    // The slave responds exactly one cycle after each handshake.
    task automatic step(input bit rst_v, input logic [N-1:0] req, input bit gnt,
                        input logic [DW-1:0] rd, input bit rv_extra);
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        bit           reqo;
        bit           rv;
        int           win;
        int           m;
        @(negedge clk);
        rv             = m_hs_prev | rv_extra;
        rst_n          = rst_v;
        data_req_i     = req;
        data_gnt_i     = gnt;
        data_r_valid_i = rv;
        data_r_rdata_i = rd;
        for (int i = 0; i < N; i++) begin
            data_add_i[i*AW +: AW]   = p_add[i];
            data_wen_i[i]            = p_wen[i];
            data_wdata_i[i*DW +: DW] = p_wdata[i];
            data_be_i[i*BW +: BW]    = p_be[i];
            data_ID_i[i*IW +: IW]    = p_id[i];
        end
        #1;
        reqo  = 1'b0;
        win   = 0;
        e_gnt = '0;
        e_rv  = '0;
        if (!rst_v) begin
            m_ptr = 0; m_locked = 0; m_lock_m = 0; m_rtarget = 0;
        end else begin
            if (m_locked) begin
                win  = m_lock_m;
                reqo = req[win];
            end else begin
                for (int k = 0; k < N; k++) begin
                    m = (m_ptr + k) % N;
                    if (!reqo && req[m]) begin
                        reqo = 1'b1;
                        win  = m;
                    end
                end
            end
            if (reqo && gnt) e_gnt[win] = 1'b1;
            if (rv) e_rv[m_rtarget] = 1'b1;
        end
        chk("req_o",     64'(data_req_o),     64'(reqo));
        chk("add_o",     64'(data_add_o),     reqo ? 64'(p_add[win])   : 64'd0);
        chk("wen_o",     64'(data_wen_o),     reqo ? 64'(p_wen[win])   : 64'd0);
        chk("wdata_o",   64'(data_wdata_o),   reqo ? 64'(p_wdata[win]) : 64'd0);
        chk("be_o",      64'(data_be_o),      reqo ? 64'(p_be[win])    : 64'd0);
        chk("id_o",      64'(data_ID_o),      reqo ? 64'(p_id[win])    : 64'd0);
        chk("gnt_o",     64'(data_gnt_o),     64'(e_gnt));
        chk("r_valid_o", 64'(data_r_valid_o), 64'(e_rv));
        chk("r_rdata_o", 64'(data_r_rdata_o), 64'(rd));
        last_hs  = rst_v && reqo && gnt;
        last_win = win;
        if (rst_v) begin
            if (last_hs) begin
                m_ptr     = (win + 1) % N;
                m_locked  = 0;
                m_rtarget = win;
            end else if (reqo) begin
                m_locked = 1;
                m_lock_m = win;
            end else begin
                m_locked = 0;
            end
        end
        m_hs_prev = last_hs;
    endtask

    initial begin
        logic [N-1:0] one;
        logic [N-1:0] pending;
        one = 4'b0001;
        pending = '0;
        rst_n = 1'b0;
        data_req_i = '0; data_add_i = '0; data_wen_i = '0; data_wdata_i = '0;
        data_be_i = '0; data_ID_i = '0; data_gnt_i = 1'b0;
        data_r_valid_i = 1'b0; data_r_rdata_i = '0;
        for (int i = 0; i < N; i++) begin
            new_payload(i);
            p_id[i] = one << i;
        end

        // reset state and idle outputs
        step(1'b0, 4'b0000, 1'b0, 32'd0, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 32'd0, 1'b0);

        // all four requesting with the slave always ready: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'b1111, 1'b1, $urandom, 1'b0);
            chk("rr_seq", 64'(data_gnt_o), 64'(one << (k % 4)));
        end

        // only master 2 requesting from pointer 3 wraps round to 2
        step(1'b1, 4'b0100, 1'b1, $urandom, 1'b0);
        step(1'b1, 4'b0100, 1'b1, $urandom, 1'b0);
        chk("wrap_gnt2", 64'(data_gnt_o), 64'(4'b0100));
        step(1'b1, 4'b1001, 1'b1, $urandom, 1'b0);
        chk("ptr_is_3", 64'(data_gnt_o), 64'(4'b1000));

        // master 1 stalled three cycles while master 0 joins
        step(1'b1, 4'b0010, 1'b0, $urandom, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'b0011, 1'b0, $urandom, 1'b0);
            chk("lock_add", 64'(data_add_o), 64'(p_add[1]));
        end
        step(1'b1, 4'b0011, 1'b1, $urandom, 1'b0);
        chk("lock_gnt1", 64'(data_gnt_o), 64'(4'b0010));
        step(1'b1, 4'b0001, 1'b1, $urandom, 1'b0);
        chk("after_gnt0", 64'(data_gnt_o), 64'(4'b0001));

        // read from master 3, response one cycle later
        p_wen[3] = 1'b1;
        step(1'b1, 4'b1000, 1'b1, $urandom, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("rd_valid3", 64'(data_r_valid_o), 64'(4'b1000));
        chk("rd_data3", 64'(data_r_rdata_o), 64'h0000_0000_DEAD_BEEF);

        // back-to-back handshakes to masters 0 then 2
        step(1'b1, 4'b0101, 1'b1, $urandom, 1'b0);
        step(1'b1, 4'b0100, 1'b1, $urandom, 1'b0);
        chk("b2b_resp0", 64'(data_r_valid_o), 64'(4'b0001));
        step(1'b1, 4'b0000, 1'b0, $urandom, 1'b0);
        chk("b2b_resp2", 64'(data_r_valid_o), 64'(4'b0100));

        // locked master withdraws: no grant, lock released next cycle
        step(1'b1, 4'b0001, 1'b0, $urandom, 1'b0);
        step(1'b1, 4'b0010, 1'b1, $urandom, 1'b0);
        chk("drop_nognt", 64'(data_gnt_o), 64'(4'b0000));
        step(1'b1, 4'b0010, 1'b1, $urandom, 1'b0);
        chk("drop_gnt1", 64'(data_gnt_o), 64'(4'b0010));

        // reset during a locked stall, with a stray response in flight
        step(1'b1, 4'b0100, 1'b0, $urandom, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 32'd0, 1'b1);
        chk("rst_valid", 64'(data_r_valid_o), 64'(4'b0000));
        step(1'b1, 4'b1111, 1'b1, $urandom, 1'b0);
        chk("rst_restart", 64'(data_gnt_o), 64'(4'b0001));

        // randomized traffic: masters hold request and payload until granted
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 99) < 40)) begin
                    pending[i] = 1'b1;
                    new_payload(i);
                end
            end
            step(1'b1, pending, ($urandom_range(0, 99) < 60), $urandom, 1'b0);
            if (last_hs) pending[last_win] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_bridge_rr_arbiter.md
# xbar_bridge_rr_arbiter

Per-slave round-robin arbiter for the L2 TCDM bridge crossbar. It collects the one-hot request lines that the per-master request decoders drive toward a single slave port, and grants one master per cycle to that slave. It holds the selection stable while the slave stalls, and routes the fixed-latency read response back to the master that won. There is one instance per bridge slave port, between the request decoders and the slave interface.

## Interface
Parameters:
- N_MASTER, 16, number of requesting masters (≥2; need not be a power of two)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, N_MASTER, width of the forwarded master ID

Ports:
- clk  in  1  clock; only clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  N_MASTER  per-master request toward this slave
- data_add_i  in  N_MASTER*ADDR_WIDTH  packed addresses, master m at slice m
- data_wen_i  in  N_MASTER  1 = read, 0 = write
- data_wdata_i  in  N_MASTER*DATA_WIDTH  packed write data
- data_be_i  in  N_MASTER*BE_WIDTH  packed byte enables
- data_ID_i  in  N_MASTER*ID_WIDTH  packed master IDs
- data_gnt_o  out  N_MASTER  one-hot grant back to masters
- data_req_o  out  1  request to slave
- data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o  out  widths as above  muxed payload of selected master
- data_gnt_i  in  1  slave grant
- data_r_valid_i  in  1  slave read/write response valid, exactly one cycle after a handshake
- data_r_rdata_i  in  DATA_WIDTH  slave response data
- data_r_valid_o  out  N_MASTER  one-hot response valid to masters
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters

## Operation
- State: rr_q (pointer, $clog2(N_MASTER) bits), lock_q (1 bit), lock_idx_q (selected master), r_idx_q (response target).
- Two modes:
  - UNLOCKED (lock_q=0): winner = first m with data_req_i[m]=1, scanning rr_q, rr_q+1, … N_MASTER-1, 0, … rr_q-1.
  - LOCKED (lock_q=1): winner = lock_idx_q, regardless of the other requests.
- data_req_o = |data_req_i in UNLOCKED, or data_req_i[lock_idx_q] in LOCKED. The payload outputs carry the winner's slices. All payload outputs are 0 when data_req_o=0.
- data_gnt_o[winner] = data_gnt_i & data_req_o. All other grant bits are 0.
- Handshake (data_req_o & data_gnt_i):
  - rr_q ← winner+1, wrapping N_MASTER-1 → 0.
  - lock_q ← 0.
  - r_idx_q ← winner.
- Stall (data_req_o & !data_gnt_i): lock_q ← 1, lock_idx_q ← winner. rr_q is unchanged.
- Masters must hold req and payload until granted. If a locked master drops its request anyway, lock_q ← 0 next cycle, and no grant is issued to it.
- Response: data_r_valid_o = data_r_valid_i ? (1 << r_idx_q) : 0. data_r_rdata_o = data_r_rdata_i.
- Back-to-back handshakes are legal. r_idx_q updates every handshake, and response k always targets handshake k.
- Reset values: rr_q=0, lock_q=0, lock_idx_q=0, r_idx_q=0. With no requests, every output is 0.

## Timing
- Request path is fully combinational: req_i → req_o, and gnt_i → gnt_o, in 0 cycles.
- Response path is combinational from the r_idx_q register. Response latency is fixed by the slave at 1 cycle.
- The arbitration pointer and lock take effect in the cycle after the event that updates them.
- If a new request from a higher-priority master arrives in the same cycle as a stall, the locked winner is kept.
- Asserting rst_n low mid-transaction clears the lock and pointer immediately. A response pending at reset is dropped, and data_r_valid_o is 0 while reset is active.
- Pointer wrap for non-power-of-two N_MASTER: the pointer never takes a value ≥ N_MASTER.

## Structure
- Sub-module rr_prio_encoder: inputs are the request vector and start pointer; outputs are a found flag and the winner index. It is purely combinational and parameterised on N_MASTER.
- No shared package types are needed. The LOG_N = $clog2(N_MASTER) localparam is local.
- Default widths stay aligned with the bridge's existing ADDR/DATA/ID parameters.

## Test plan
- N_MASTER=4, all four requests held and data_gnt_i=1 → grants 0,1,2,3,0 on consecutive cycles.
- Only master 2 requesting, rr_q=3 → wrap-around scan grants master 2, and rr_q becomes 3.
- Master 1 wins with data_gnt_i=0 for 3 cycles while master 0 starts requesting → req_o stays with master 1's payload. Master 1 is granted on cycle 4, then master 0 is granted next.
- Read from master 3 handshakes at cycle t, data_r_valid_i=1 with rdata=0xDEADBEEF at t+1 → data_r_valid_o=4'b1000 and rdata=0xDEADBEEF.
- Back-to-back handshakes to masters 0 then 2 → responses arrive at 4'b0001 then 4'b0100.
- rst_n pulsed low during a locked stall → all outputs 0, rr_q=0, and arbitration restarts from master 0.
